// File: rtl/flappy_pkg.sv
// Shared types and constants for the Flappy Bird video datapath.
package flappy_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef logic [10:0] coord_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DEAD
    } game_state_t;

    // Right edge of pipe idx at game start: just off the right of the screen, evenly spaced.
    function automatic coord_t pipe_x_init(input int idx, input int pipe_w, input int spacing);
        return coord_t'(SCREEN_W + pipe_w + idx * spacing);
    endfunction

    // Gap top of pipe idx at game start: a fixed staircase so the first pipes are deterministic.
    function automatic logic [9:0] pipe_gap_init(input int idx, input int gap_min);
        return 10'(gap_min + 'h40 * idx);
    endfunction

endpackage

// File: rtl/pipe_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), free-running every clock.
module pipe_lfsr
    import flappy_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_SEED
) (
    input  logic        Clk,
    input  logic        Reset,
    output logic [15:0] q
);

    logic fb;

    assign fb = q[0] ^ q[2] ^ q[3] ^ q[5];

    // Shift right, feeding the tap XOR into the MSB.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            q <= SEED;
        end else begin
            q <= {fb, q[15:1]};
        end
    end

endmodule

// File: rtl/pipe_scroller.sv
// Scrolling pipe obstacles: per-frame motion, per-pixel pipe test and score pulses.
module pipe_scroller
    import flappy_pkg::*;
#(
    parameter int NUM_PIPES = 3,
    parameter int PIPE_W    = 52,
    parameter int SPACING   = 240,
    parameter int SPEED     = 2,
    parameter int GAP_H     = 120,
    parameter int GAP_MIN   = 64
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       start,
    input  logic       halt,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic [9:0] BallX,
    output logic       pipe_on,
    output logic       score_tick,
    output logic       running
);

    // Elaboration-time parameter sanity.
    if (NUM_PIPES < 1 || NUM_PIPES > 4) begin : g_chk_num
        $error("pipe_scroller: NUM_PIPES must be in 1..4");
    end
    if (SPEED < 1 || SPEED > 8 || SPEED >= PIPE_W) begin : g_chk_speed
        $error("pipe_scroller: SPEED must be 1..8 and below PIPE_W");
    end
    if (SPACING <= SPEED) begin : g_chk_spacing
        $error("pipe_scroller: SPACING must exceed SPEED");
    end
    if (GAP_MIN + 255 + GAP_H > SCREEN_H - 1) begin : g_chk_gap
        $error("pipe_scroller: gap can extend below the visible screen");
    end

    localparam coord_t     SPEED_C   = coord_t'(SPEED);
    localparam coord_t     WRAP_C    = coord_t'(NUM_PIPES * SPACING);
    localparam coord_t     PIPE_W_C  = coord_t'(PIPE_W);
    localparam logic [9:0] GAP_H_C   = 10'(GAP_H);
    localparam logic [9:0] GAP_MIN_C = 10'(GAP_MIN);

    // ---------------- frame tick ----------------
    logic frame_p0, frame_p1, frame_p2;
    logic tick;

    // Two-flop synchroniser plus one history flop for rising-edge detection.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_p0 <= 1'b0;
            frame_p1 <= 1'b0;
            frame_p2 <= 1'b0;
        end else begin
            frame_p0 <= frame_clk;
            frame_p1 <= frame_p0;
            frame_p2 <= frame_p1;
        end
    end

    assign tick = frame_p1 & ~frame_p2;

    // ---------------- game state ----------------
    game_state_t state, state_nxt;
    logic        move;
    logic        reinit;

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state; halt wins over a coincident tick so a crash freezes the pipes in place.
    always_comb begin
        state_nxt = state;
        move      = 1'b0;
        reinit    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nxt = RUN;
            end
            RUN: begin
                if (halt) begin
                    state_nxt = DEAD;
                end else if (tick) begin
                    move = 1'b1;
                end
            end
            DEAD: begin
                if (start) begin
                    state_nxt = IDLE;
                    reinit    = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign running = (state == RUN);

    // ---------------- gap randomiser ----------------
    logic [15:0] lfsr_q;
    logic [9:0]  new_gap;
    logic        unused_lfsr_hi;

    pipe_lfsr #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .Clk  (Clk),
        .Reset(Reset),
        .q    (lfsr_q)
    );

    // Only the low byte picks gap heights; the rest just feeds the shift chain.
    assign unused_lfsr_hi = ^lfsr_q[15:8];
    assign new_gap        = GAP_MIN_C + {2'b00, lfsr_q[7:0]};

    // ---------------- per-pipe datapath ----------------
    coord_t               xr       [NUM_PIPES];
    logic [9:0]           gtop     [NUM_PIPES];
    coord_t               xr_nxt   [NUM_PIPES];
    logic [9:0]           gtop_nxt [NUM_PIPES];
    logic [NUM_PIPES-1:0] body;
    logic [NUM_PIPES-1:0] passed;
    coord_t               draw_x;
    coord_t               ball_x;

    assign draw_x = {1'b0, DrawX};
    assign ball_x = {1'b0, BallX};

    for (genvar i = 0; i < NUM_PIPES; i++) begin : g_pipe
        logic   cov;
        logic   wrap;
        coord_t xr_dec;

        assign cov     = (draw_x < xr[i]) && (draw_x + PIPE_W_C >= xr[i]);
        assign body[i] = cov && ((DrawY < gtop[i]) || (DrawY >= gtop[i] + GAP_H_C));

        // A pipe that would reach the left edge jumps back by the full ring length,
        // so the spacing to its neighbours stays exact after the wrap.
        assign wrap        = (xr[i] <= SPEED_C);
        assign xr_dec      = xr[i] - SPEED_C;
        assign xr_nxt[i]   = wrap ? xr_dec + WRAP_C : xr_dec;
        assign gtop_nxt[i] = wrap ? new_gap : gtop[i];
        assign passed[i]   = !wrap && (xr[i] > ball_x) && (xr_dec <= ball_x);
    end

    // Pipe positions: reload on reset or restart, advance on a running frame tick.
    always_ff @(posedge Clk) begin
        if (Reset || reinit) begin
            for (int k = 0; k < NUM_PIPES; k++) begin
                xr[k]   <= pipe_x_init(k, PIPE_W, SPACING);
                gtop[k] <= pipe_gap_init(k, GAP_MIN);
            end
        end else if (move) begin
            for (int k = 0; k < NUM_PIPES; k++) begin
                xr[k]   <= xr_nxt[k];
                gtop[k] <= gtop_nxt[k];
            end
        end
    end

    // Registered pixel answer and score pulse, both from pre-update pipe state.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pipe_on    <= 1'b0;
            score_tick <= 1'b0;
        end else begin
            pipe_on    <= |body;
            score_tick <= move && (|passed);
        end
    end

endmodule
